// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, bit divider
// helper and the default RTS threshold.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAITHI
    } rx_state_t;

    localparam int RTS_HI_DEFAULT = 12;

    // Rounded clocks-per-bit.
    function automatic int uart_div(input int clkhz, input int bps);
        return (clkhz + bps / 2) / bps;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO: rdata always presents the head entry and
// reads as zero while empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LVL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign level   = level_reg;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_rx_rts.sv
// 8N1 UART receiver feeding a FWFT FIFO, with sticky error flags and an RTS
// output derived from the FIFO fill level.
module uart_rx_rts
    import uart_pkg::*;
#(
    parameter int CLKHZ  = 28000000,
    parameter int BPS    = 115200,
    parameter int DEPTH  = 16,
    parameter int RTS_HI = RTS_HI_DEFAULT
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   uart_rx,
    input  logic                   rd,
    output logic [7:0]             data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   framing_error,
    output logic                   overrun,
    input  logic                   clr_err,
    output logic                   uart_rts
);

    localparam int DIV   = uart_div(CLKHZ, BPS);
    localparam int CNT_W = $clog2(DIV);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] RTS_LVL  = LVL_W'(RTS_HI);

    logic [1:0]       sync_reg;
    logic             rx_s;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             push_reg, push_next;
    logic             fe_set;
    logic             ov_set;
    logic             fe_reg;
    logic             ov_reg;
    logic             rts_reg;
    logic             fifo_full;

    // Flops reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_rx};
        end
    end
    assign rx_s = sync_reg[1];

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            push_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            push_reg  <= push_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push_next  = 1'b0;
        fe_set     = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = RX_START;
                    bit_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_END) begin
                    cnt_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_END) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_END) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        push_next  = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        fe_set     = 1'b1;
                        state_next = RX_WAITHI;
                    end
                end
            end
            RX_WAITHI: begin
                // Hold off until the line returns high so a break is one error.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    // shift_reg is stable until the next frame's first data bit, well after the push.
    uart_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (rst),
        .push  (push_reg),
        .wdata (shift_reg),
        .pop   (rd),
        .rdata (data),
        .full  (fifo_full),
        .empty (empty),
        .level (level)
    );

    assign ov_set = push_reg && fifo_full && !rd;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            fe_reg  <= 1'b0;
            ov_reg  <= 1'b0;
            rts_reg <= 1'b0;
        end else begin
            fe_reg  <= fe_set | (fe_reg & ~clr_err);
            ov_reg  <= ov_set | (ov_reg & ~clr_err);
            rts_reg <= (level >= RTS_LVL);
        end
    end

    assign framing_error = fe_reg;
    assign overrun       = ov_reg;
    assign uart_rts      = rts_reg;

endmodule

// File: tb/tb_uart_rx_rts.sv
// Bench for uart_rx_rts: directed frame table, hand-written corner sequences
// and randomized frames checked against a byte-level FIFO/flag model.
module tb_uart_rx_rts;

    localparam int BITC      = 243;
    localparam int BITC_FAST = 236;
    localparam int BITC_SLOW = 250;
    localparam int DEPTH     = 16;
    localparam int RTS_HI    = 12;
    // Pin low first captured at edge 1, +2 sync, start/data/stop samples,
    // then the push lands one edge after the stop sample.
    localparam int PUSH_DLY  = 2 + BITC / 2 + 9 * BITC + 1;

    logic       sysclk;
    logic       rst;
    logic       uart_rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] data;
    logic       empty;
    logic [4:0] level;
    logic       framing_error;
    logic       overrun;
    logic       uart_rts;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       m_fe;
    logic       m_ov;

    typedef struct {
        logic [7:0] b;
        int         bitc;
        logic       stop_ok;
        int         exp_level;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[5];

    uart_rx_rts dut (
        .sysclk        (sysclk),
        .rst           (rst),
        .uart_rx       (uart_rx),
        .rd            (rd),
        .data          (data),
        .empty         (empty),
        .level         (level),
        .framing_error (framing_error),
        .overrun       (overrun),
        .clr_err       (clr_err),
        .uart_rts      (uart_rts)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        repeat (150000) @(posedge sysclk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, "_level"}, 32'(level), 32'(n));
        check({tag, "_empty"}, 32'(empty), 32'(n == 0));
        if (n > 0) check({tag, "_data"}, 32'(data), 32'(q[0]));
        check({tag, "_rts"}, 32'(uart_rts), 32'(n >= RTS_HI));
        check({tag, "_fe"}, 32'(framing_error), 32'(m_fe));
        check({tag, "_ov"}, 32'(overrun), 32'(m_ov));
    endtask

    task automatic m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ov = 1'b1;
    endtask

    task automatic m_pop();
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic send_frame(input logic [7:0] b, input int bitc, input logic stop_ok);
        $display("frame 0x%02h bitc=%0d stop_ok=%0d", b, bitc, stop_ok);
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (bitc) @(negedge sysclk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (bitc) @(negedge sysclk);
        end
        uart_rx = stop_ok;
        repeat (stop_ok ? bitc : 2 * bitc) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic pop_dut();
        @(negedge sysclk);
        rd = 1'b1;
        @(negedge sysclk);
        rd = 1'b0;
    endtask

    task automatic clr_dut();
        @(negedge sysclk);
        clr_err = 1'b1;
        @(negedge sysclk);
        clr_err = 1'b0;
    endtask

    initial begin
        logic       hold_ok;
        logic [7:0] rb;
        int         rbitc;
        logic       rgood;

        tbl[0] = '{8'h55, BITC, 1'b1, 1, 8'h55, 1'b0};
        tbl[1] = '{8'hA3, BITC, 1'b1, 2, 8'h55, 1'b0};
        tbl[2] = '{8'h00, BITC, 1'b1, 3, 8'h55, 1'b0};
        tbl[3] = '{8'h7E, BITC, 1'b0, 0, 8'h00, 1'b1};
        tbl[4] = '{8'h42, BITC, 1'b1, 1, 8'h42, 1'b1};

        rst = 1'b1; uart_rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        m_fe = 1'b0; m_ov = 1'b0;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        check("reset_data", 32'(data), 32'h00);
        check_all("reset");

        // Three good bytes, then drain in order.
        for (int i = 0; i < 3; i++) begin
            send_frame(tbl[i].b, tbl[i].bitc, tbl[i].stop_ok);
            check("tbl_level", 32'(level), 32'(tbl[i].exp_level));
            check("tbl_data", 32'(data), 32'(tbl[i].exp_data));
            check("tbl_empty", 32'(empty), 32'(0));
            check("tbl_fe", 32'(framing_error), 32'(tbl[i].exp_fe));
        end
        pop_dut();
        check("pop1_data", 32'(data), 32'hA3);
        check("pop1_level", 32'(level), 32'd2);
        pop_dut();
        check("pop2_data", 32'(data), 32'h00);
        check("pop2_level", 32'(level), 32'd1);
        pop_dut();
        check("pop3_empty", 32'(empty), 32'd1);
        check("pop3_level", 32'(level), 32'd0);

        // Framing error frame followed by a good one.
        for (int i = 3; i < 5; i++) begin
            send_frame(tbl[i].b, tbl[i].bitc, tbl[i].stop_ok);
            check("tbl_level", 32'(level), 32'(tbl[i].exp_level));
            if (tbl[i].exp_level != 0) check("tbl_data", 32'(data), 32'(tbl[i].exp_data));
            check("tbl_empty", 32'(empty), 32'(tbl[i].exp_level == 0));
            check("tbl_fe", 32'(framing_error), 32'(tbl[i].exp_fe));
        end
        clr_dut();
        check("clr_fe", 32'(framing_error), 32'd0);
        pop_dut();
        check("pop42_empty", 32'(empty), 32'd1);

        // 50-cycle glitch: no push, receiver idle again in time for a real frame.
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (50) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (80) @(negedge sysclk);
        check("glitch_level", 32'(level), 32'd0);
        check("glitch_empty", 32'(empty), 32'd1);
        pop_dut();
        check("pop_empty_level", 32'(level), 32'd0);
        send_frame(8'h3C, BITC, 1'b1);
        m_push(8'h3C);
        check_all("after_glitch");
        pop_dut();
        m_pop();
        check_all("after_glitch_pop");

        // Fill past capacity with no reads.
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), BITC, 1'b1);
            m_push(8'(i));
            check_all($sformatf("fill%0d", i));
        end

        // Full FIFO, rd exactly on the push edge.
        clr_dut();
        m_ov = 1'b0;
        check_all("full_clr");
        hold_ok = 1'b1;
        fork
            send_frame(8'h99, BITC, 1'b1);
            begin
                @(negedge sysclk);
                repeat (PUSH_DLY) @(negedge sysclk);
                rd = 1'b1;
                @(negedge sysclk);
                rd = 1'b0;
            end
            begin
                repeat (PUSH_DLY + 40) begin
                    @(negedge sysclk);
                    if (level !== 5'd16) hold_ok = 1'b0;
                end
            end
        join
        m_pop();
        m_push(8'h99);
        check("full_rd_level_hold", 32'(hold_ok), 32'd1);
        check_all("full_rd");
        pop_dut();
        m_pop();
        check_all("full_rd_pop");

        // Reset during bit 4 of 0xF0 (line high for the rest of that frame).
        fork
            send_frame(8'hF0, BITC, 1'b1);
            begin
                @(negedge sysclk);
                repeat (5 * BITC + 100) @(negedge sysclk);
                rst = 1'b1;
                #1;
                q.delete();
                m_fe = 1'b0;
                m_ov = 1'b0;
                check("rst_mid_data", 32'(data), 32'h00);
                check_all("rst_mid");
                repeat (3) @(negedge sysclk);
                rst = 1'b0;
            end
        join
        check_all("rst_after");
        send_frame(8'hC9, BITC, 1'b1);
        m_push(8'hC9);
        check_all("rst_c9");

        // Randomized frames with bit-rate skew, bad stops, pops and clears.
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                clr_dut();
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0: rbitc = BITC_FAST;
                1: rbitc = BITC_SLOW;
                default: rbitc = BITC;
            endcase
            rgood = ($urandom_range(0, 3) != 0);
            send_frame(rb, rbitc, rgood);
            if (rgood) m_push(rb);
            else m_fe = 1'b1;
            check_all($sformatf("rand%0d", i));
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                pop_dut();
                m_pop();
                check_all($sformatf("rand%0d_pop", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
